alu_result_collector: RTL

- Downstream stage of the signed ALU execution units (arithmetic, logic, compare, shift).
- Each cycle it samples the four registered unit results and their one-cycle valid flags, and selects one result by fixed priority.
- The selected result is tagged with its source and buffered in a small first-word-fall-through FIFO.
- The FIFO is drained by a valid/ready consumer. Sticky error flags report result collisions and dropped results.

---
 rtl/alu_result_collector.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_collector
// Description : Samples the four ALU unit results each cycle, picks one by
//               fixed priority (Arith > Logic > CMP > Shift), tags it with its
//               source and buffers it in a first-word-fall-through FIFO that is
//               drained by a valid/ready consumer. Sticky flags report flag
//               collisions and results dropped on a full FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_collector #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,          // asynchronous, active low
    input  logic signed [DATA_W-1:0]   Arith_Out,
    input  logic                       Arith_Flag,
    input  logic        [DATA_W-1:0]   Logic_Out,
    input  logic                       Logic_Flag,
    input  logic        [DATA_W-1:0]   CMP_Out,
    input  logic                       CMP_Flag,
    input  logic signed [DATA_W-1:0]   Shift_Out,
    input  logic                       Shift_Flag,
    input  logic                       res_ready,
    input  logic                       err_clr,
    output logic                       res_valid,
    output logic        [DATA_W-1:0]   res_data,
    output logic        [1:0]          res_src,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       collision_err,
    output logic                       overflow_err,
    output logic        [CNT_W-1:0]    drop_cnt
);

    localparam int                    c_ADDR_W    = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]     c_FULL      = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]      c_CNT_MAX   = '1;
    localparam logic [1:0]            c_SRC_ARITH = 2'd0;
    localparam logic [1:0]            c_SRC_LOGIC = 2'd1;
    localparam logic [1:0]            c_SRC_CMP   = 2'd2;
    localparam logic [1:0]            c_SRC_SHIFT = 2'd3;

    // Each entry holds {source tag, data}
    logic [DATA_W+1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                r_collision;
    logic                r_overflow;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic                w_push;
    logic [1:0]          w_src;
    logic [DATA_W-1:0]   w_data;
    logic [2:0]          w_nflags;
    logic                w_collision;
    logic                w_full;
    logic                w_pop;
    logic                w_accept;
    logic                w_drop;
    logic [DATA_W+1:0]   w_head;

    // Fixed-priority winner selection; losers are simply discarded
    always_comb begin
        w_push   = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
        w_src    = c_SRC_SHIFT;
        w_data   = Shift_Out;
        if (Arith_Flag) begin
            w_src  = c_SRC_ARITH;
            w_data = Arith_Out;
        end else if (Logic_Flag) begin
            w_src  = c_SRC_LOGIC;
            w_data = Logic_Out;
        end else if (CMP_Flag) begin
            w_src  = c_SRC_CMP;
            w_data = CMP_Out;
        end
        w_nflags    = {2'b00, Arith_Flag} + {2'b00, Logic_Flag}
                    + {2'b00, CMP_Flag}   + {2'b00, Shift_Flag};
        w_collision = (w_nflags > 3'd1);
    end

    // Handshake and full handling: a pop in the same cycle frees room for the push
    always_comb begin
        w_full   = (r_count == c_FULL);
        w_pop    = res_valid & res_ready;
        w_accept = w_push & (~w_full | w_pop);
        w_drop   = w_push & w_full & ~w_pop;
    end

    // Storage array carries no reset; validity is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {w_src, w_data};
        end
    end

    // Pointers and occupancy; power-of-two depth makes pointer wrap implicit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags and saturating drop counter; a new event beats err_clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_collision <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_collision)  r_collision <= 1'b1;
            else if (err_clr) r_collision <= 1'b0;

            if (w_drop)       r_overflow <= 1'b1;
            else if (err_clr) r_overflow <= 1'b0;

            if (err_clr) begin
                r_drop_cnt <= w_drop ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            end else if (w_drop && (r_drop_cnt != c_CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Head entry falls through; outputs read zero while empty
    always_comb begin
        w_head        = r_mem[r_rd_ptr];
        res_valid     = (r_count != '0);
        res_data      = res_valid ? w_head[DATA_W-1:0]      : '0;
        res_src       = res_valid ? w_head[DATA_W+1:DATA_W] : 2'd0;
        fifo_count    = r_count;
        collision_err = r_collision;
        overflow_err  = r_overflow;
        drop_cnt      = r_drop_cnt;
    end

endmodule
`default_nettype wire
